m_wb_uarttx: RTL and testbench

- Wishbone classic slave on the midgetv core data bus, sitting beside the scratch register in the address map and consuming core store cycles.
- Buffers bytes written by software in a small FIFO and serialises them on a TX line as 8N1 frames.
- Gives the ice40 builds and the verilator testbench a character output that needs no SRAM.

---
 rtl/m_wb_uarttx_pkg.sv | 21 ++
 rtl/m_wb_uarttx_fifo.sv | 52 +++++
 rtl/m_wb_uarttx.sv | 152 +++++++++++++++
 tb/tb_m_wb_uarttx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_wb_uarttx_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register map,
// STATUS bit positions and the serialiser state encoding.
package m_wb_uarttx_pkg;

  localparam logic UARTTX_DATA   = 1'b0;
  localparam logic UARTTX_STATUS = 1'b1;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } txstate_t;

endpackage

// File: rtl/m_wb_uarttx_fifo.sv
// Byte FIFO for the UART transmitter: register array with extra-MSB pointers,
// combinational head read so the serialiser can pop and load in one cycle.
module m_uarttx_fifo
  import m_wb_uarttx_pkg::*;
#(
  parameter int FIFOLOG2 = 3
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                push,
  input  logic [7:0]          wdat,
  input  logic                pop,
  output logic [7:0]          rdat,
  output logic                full,
  output logic                empty,
  output logic [FIFOLOG2:0]   count
);

  localparam int DEPTH = 2 ** FIFOLOG2;
  localparam logic [FIFOLOG2:0] PTR_ONE = 1;

  logic [7:0]        r_mem [DEPTH];
  logic [FIFOLOG2:0] r_wptr;
  logic [FIFOLOG2:0] r_rptr;
  logic              w_doPush;
  logic              w_doPop;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[FIFOLOG2] != r_rptr[FIFOLOG2]) &&
                 (r_wptr[FIFOLOG2-1:0] == r_rptr[FIFOLOG2-1:0]);
  assign count = r_wptr - r_rptr;
  assign rdat  = r_mem[r_rptr[FIFOLOG2-1:0]];

  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign w_doPop  = pop & ~empty;
  assign w_doPush = push & (~full | w_doPop);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_doPush) r_wptr <= r_wptr + PTR_ONE;
      if (w_doPop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (w_doPush) r_mem[r_wptr[FIFOLOG2-1:0]] <= wdat;
  end

endmodule

// File: rtl/m_wb_uarttx.sv
// Wishbone classic slave that queues bytes written to DATA and sends them
// on TXD as 8N1 frames; STATUS exposes FIFO state and a sticky overflow flag.
module m_wb_uarttx
  import m_wb_uarttx_pkg::*;
#(
  parameter int CLKDIV   = 104,
  parameter int FIFOLOG2 = 3
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic        ADR_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        TXD
);

  localparam int BW = $clog2(CLKDIV);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKDIV - 1);
  localparam logic [BW-1:0] BAUD_ONE    = BW'(1);

  logic              r_ack;
  logic [31:0]       r_dat;
  logic              r_ovf;
  logic              r_txd;
  txstate_t          r_state;
  logic [BW-1:0]     r_baud;
  logic [2:0]        r_bitIdx;
  logic [7:0]        r_shift;

  logic              w_acc;
  logic              w_push;
  logic              w_statRd;
  logic              w_pop;
  logic              w_ovfEvt;
  logic              w_busy;
  logic              w_full;
  logic              w_empty;
  logic [7:0]        w_head;
  logic [FIFOLOG2:0] w_count;
  logic [31:0]       w_status;
  logic              w_unused;

  assign w_unused = ^{DAT_I[31:8], SEL_I[3:1]};

  m_uarttx_fifo #(.FIFOLOG2(FIFOLOG2)) u_fifo (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .push  (w_push),
    .wdat  (DAT_I[7:0]),
    .pop   (w_pop),
    .rdat  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Side effects happen only in the ack cycle, so one access acts once.
  assign w_acc    = STB_I & r_ack;
  assign w_push   = w_acc & WE_I & (ADR_I == UARTTX_DATA) & SEL_I[0];
  assign w_statRd = w_acc & ~WE_I & (ADR_I == UARTTX_STATUS);
  assign w_pop    = (r_state == ST_IDLE) & ~w_empty;
  assign w_ovfEvt = w_push & w_full & ~w_pop;
  assign w_busy   = (r_state != ST_IDLE) | ~w_empty;

  always_comb begin
    w_status                      = '0;
    w_status[STAT_FULL]           = w_full;
    w_status[STAT_EMPTY]          = w_empty;
    w_status[STAT_BUSY]           = w_busy;
    w_status[STAT_OVF]            = r_ovf;
    w_status[STAT_CNT_LSB +: 8]   = 8'(w_count);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_ack <= STB_I & ~r_ack;
      r_dat <= (STB_I & ~r_ack & ~WE_I & (ADR_I == UARTTX_STATUS)) ? w_status : '0;
      // A fresh overflow beats the clear-on-read.
      if (w_ovfEvt)      r_ovf <= 1'b1;
      else if (w_statRd) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state  <= ST_IDLE;
      r_txd    <= 1'b1;
      r_baud   <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_txd <= 1'b1;
          if (!w_empty) begin
            r_shift <= w_head;
            r_baud  <= BAUD_RELOAD;
            r_txd   <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_baud == '0) begin
            r_baud   <= BAUD_RELOAD;
            r_bitIdx <= 3'd0;
            r_txd    <= r_shift[0];
            r_state  <= ST_DATA;
          end else begin
            r_baud <= r_baud - BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (r_baud == '0) begin
            r_baud <= BAUD_RELOAD;
            if (r_bitIdx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_shift  <= r_shift >> 1;
              r_txd    <= r_shift[1];
              r_bitIdx <= r_bitIdx + 3'd1;
            end
          end else begin
            r_baud <= r_baud - BAUD_ONE;
          end
        end
        ST_STOP: begin
          if (r_baud == '0) begin
            r_txd   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_baud <= r_baud - BAUD_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ACK_O = r_ack;
  assign DAT_O = r_dat;
  assign TXD   = r_txd;

endmodule

// File: tb/tb_m_wb_uarttx.sv
// Self-checking bench for m_wb_uarttx: a fast instance (CLKDIV=4) whose TXD is
// decoded against a byte scoreboard, and a slow instance used to fill the FIFO.
module tb_m_wb_uarttx;
  import m_wb_uarttx_pkg::*;

  logic clk = 1'b0;
  longint cycle = 0;

  logic        fRst = 1'b1, fStb = 1'b0, fWe = 1'b0, fAdr = 1'b0;
  logic [3:0]  fSel = 4'h0;
  logic [31:0] fDin = '0;
  logic [31:0] fDout;
  logic        fAck, fTxd;

  logic        sRst = 1'b1, sStb = 1'b0, sWe = 1'b0, sAdr = 1'b0;
  logic [3:0]  sSel = 4'h0;
  logic [31:0] sDin = '0;
  logic [31:0] sDout;
  logic        sAck, sTxd;

  int checks = 0;
  int passes = 0;

  logic [7:0] expQ[$];
  int     frameCount = 0;
  longint frameStart = 0;
  longint lastStart = 0;
  bit     lastValid = 1'b0;
  bit     b2bMode = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  m_wb_uarttx #(.CLKDIV(4), .FIFOLOG2(3)) u_dutFast (
    .CLK_I(clk), .RST_I(fRst), .STB_I(fStb), .WE_I(fWe), .ADR_I(fAdr),
    .SEL_I(fSel), .DAT_I(fDin), .DAT_O(fDout), .ACK_O(fAck), .TXD(fTxd)
  );

  m_wb_uarttx #(.CLKDIV(65535), .FIFOLOG2(3)) u_dutSlow (
    .CLK_I(clk), .RST_I(sRst), .STB_I(sStb), .WE_I(sWe), .ADR_I(sAdr),
    .SEL_I(sSel), .DAT_I(sDin), .DAT_O(sDout), .ACK_O(sAck), .TXD(sTxd)
  );

  // Frame decoder for the fast instance: checks every cycle of a 40-cycle
  // frame and compares the byte with the head of the scoreboard.
  longint     monStart;
  bit         monShapeOk, monAborted;
  logic [7:0] monByte, monExp;
  initial begin
    forever begin
      @(negedge clk);
      if (fRst !== 1'b0 || fTxd !== 1'b0) continue;
      monStart = cycle; monShapeOk = 1'b1; monAborted = 1'b0; monByte = '0;
      for (int k = 0; k < 40; k++) begin
        if (k > 0) @(negedge clk);
        if (fRst !== 1'b0) begin monAborted = 1'b1; break; end
        if (k < 4) begin
          if (fTxd !== 1'b0) monShapeOk = 1'b0;
        end else if (k >= 36) begin
          if (fTxd !== 1'b1) monShapeOk = 1'b0;
        end else if ((k % 4) == 0) begin
          monByte[(k - 4) / 4] = fTxd;
        end else if (fTxd !== monByte[(k - 4) / 4]) begin
          monShapeOk = 1'b0;
        end
      end
      if (!monAborted) begin
        checks++;
        if (!monShapeOk) $display("[TB] FAIL frame_shape: frame starting cycle %0d not steady 8N1", monStart);
        else passes++;
        checks++;
        if (expQ.size() == 0) begin
          $display("[TB] FAIL frame_unexpected: got byte %h, want no frame", monByte);
        end else begin
          monExp = expQ.pop_front();
          if (monByte !== monExp) $display("[TB] FAIL frame_byte: got %h, want %h", monByte, monExp);
          else passes++;
        end
        if (b2bMode && lastValid) begin
          checks++;
          if (monStart - lastStart != 41)
            $display("[TB] FAIL frame_gap: got %0d cycles, want 41", monStart - lastStart);
          else passes++;
        end
        lastValid  = 1'b1;
        lastStart  = monStart;
        frameStart = monStart;
        frameCount++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // One Wishbone access, STB held through the ack cycle; sideEdge is the
  // cycle number of the edge on which the access takes effect.
  task automatic busAccess(input bit slow, input bit we, input bit adr, input logic [3:0] sel,
                           input logic [31:0] wdat, output logic [31:0] rdat,
                           output int latency, output longint sideEdge);
    latency = 0; rdat = '0; sideEdge = 0;
    if (slow) begin sStb = 1'b1; sWe = we; sAdr = adr; sSel = sel; sDin = wdat; end
    else      begin fStb = 1'b1; fWe = we; fAdr = adr; fSel = sel; fDin = wdat; end
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if ((slow ? sAck : fAck) === 1'b1) begin
        latency = i; rdat = slow ? sDout : fDout; sideEdge = cycle + 1;
        break;
      end
    end
    if (latency == 0) begin
      checks++;
      $display("[TB] FAIL ack_timeout: got no ack in 8 cycles, want ack");
    end else begin
      @(posedge clk); #1;
    end
    if (slow) sStb = 1'b0; else fStb = 1'b0;
  endtask

  task automatic waitFrames(input int target, input int limit);
    int n = 0;
    while (frameCount < target && n < limit) begin @(posedge clk); n++; end
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat; longint se;
    fRst = 1'b1; sRst = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if (fAck !== 1'b0 || sAck !== 1'b0) $display("[TB] FAIL reset_ack: got %b%b, want 00", fAck, sAck); else passes++;
    checks++; if (fDout !== 32'h0 || sDout !== 32'h0) $display("[TB] FAIL reset_dat: got %h/%h, want 0", fDout, sDout); else passes++;
    checks++; if (fTxd !== 1'b1 || sTxd !== 1'b1) $display("[TB] FAIL reset_txd: got %b%b, want 11", fTxd, sTxd); else passes++;
    fRst = 1'b0; sRst = 1'b0;
    busAccess(1'b0, 1'b0, UARTTX_STATUS, 4'hF, 32'h0, rd, lat, se);
    checks++; if (lat != 1) $display("[TB] FAIL reset_ack_latency: got %0d, want 1", lat); else passes++;
    checks++; if (rd !== 32'h2) $display("[TB] FAIL reset_status: got %h, want 00000002", rd); else passes++;
    checks++; if (fAck !== 1'b0) $display("[TB] FAIL ack_width: got %b, want 0", fAck); else passes++;
    checks++; if (fTxd !== 1'b1) $display("[TB] FAIL reset_txd_idle: got %b, want 1", fTxd); else passes++;
  endtask

  task automatic test_frame();
    logic [31:0] rd; int lat; longint se; int f0;
    f0 = frameCount;
    busAccess(1'b0, 1'b1, UARTTX_DATA, 4'h1, 32'hFFFFFF55, rd, lat, se);
    expQ.push_back(8'h55);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL write_dat: got %h, want 0", rd); else passes++;
    busAccess(1'b0, 1'b0, UARTTX_STATUS, 4'hF, 32'h0, rd, lat, se);
    checks++; if (rd !== 32'h104) $display("[TB] FAIL frame_status_busy: got %h, want 00000104", rd); else passes++;
    busAccess(1'b0, 1'b0, UARTTX_DATA, 4'hF, 32'h0, rd, lat, se);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL data_read: got %h, want 0", rd); else passes++;
    waitFrames(f0 + 1, 200);
    checks++; if (frameCount != f0 + 1) $display("[TB] FAIL frame_count: got %0d, want %0d", frameCount, f0 + 1); else passes++;
    busAccess(1'b0, 1'b0, UARTTX_STATUS, 4'hF, 32'h0, rd, lat, se);
    checks++; if (rd !== 32'h2) $display("[TB] FAIL frame_status_idle: got %h, want 00000002", rd); else passes++;
  endtask

  task automatic test_frame_latency();
    logic [31:0] rd; int lat; longint se; int f0;
    f0 = frameCount;
    busAccess(1'b0, 1'b1, UARTTX_DATA, 4'h1, 32'h000000F0, rd, lat, se);
    expQ.push_back(8'hF0);
    waitFrames(f0 + 1, 200);
    checks++; if (frameStart != se + 1) $display("[TB] FAIL pop_latency: got start %0d, want %0d", frameStart, se + 1); else passes++;
  endtask

  task automatic test_held_strobe();
    int acks = 0; int f0;
    f0 = frameCount;
    fStb = 1'b1; fWe = 1'b1; fAdr = UARTTX_DATA; fSel = 4'h1; fDin = 32'h000000A5;
    expQ.push_back(8'hA5);
    repeat (2) begin @(posedge clk); #1; if (fAck === 1'b1) acks++; end
    fStb = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (fAck === 1'b1) acks++; end
    checks++; if (acks != 1) $display("[TB] FAIL held_ack_pulses: got %0d, want 1", acks); else passes++;
    waitFrames(f0 + 1, 200);
    repeat (60) @(posedge clk); #1;
    checks++; if (frameCount != f0 + 1) $display("[TB] FAIL held_frames: got %0d, want %0d", frameCount - f0, 1); else passes++;
    checks++; if (expQ.size() != 0) $display("[TB] FAIL held_queue: got %0d left, want 0", expQ.size()); else passes++;
  endtask

  task automatic test_ignored_writes();
    logic [31:0] rd; int lat; longint se; int f0;
    f0 = frameCount;
    busAccess(1'b0, 1'b1, UARTTX_DATA, 4'hE, 32'h00000099, rd, lat, se);
    busAccess(1'b0, 1'b1, UARTTX_STATUS, 4'hF, 32'hFFFFFFFF, rd, lat, se);
    busAccess(1'b0, 1'b0, UARTTX_STATUS, 4'hF, 32'h0, rd, lat, se);
    checks++; if (rd !== 32'h2) $display("[TB] FAIL ignored_status: got %h, want 00000002", rd); else passes++;
    repeat (50) @(posedge clk); #1;
    checks++; if (frameCount != f0) $display("[TB] FAIL ignored_frames: got %0d, want 0", frameCount - f0); else passes++;
  endtask

  task automatic test_overflow();
    logic [31:0] rd; int lat; longint se;
    for (int i = 1; i <= 9; i++)
      busAccess(1'b1, 1'b1, UARTTX_DATA, 4'h1, 32'(i), rd, lat, se);
    busAccess(1'b1, 1'b0, UARTTX_STATUS, 4'hF, 32'h0, rd, lat, se);
    checks++; if (rd !== 32'h805) $display("[TB] FAIL ovf_full: got %h, want 00000805", rd); else passes++;
    busAccess(1'b1, 1'b1, UARTTX_DATA, 4'h1, 32'h0000000A, rd, lat, se);
    checks++; if (lat != 1) $display("[TB] FAIL ovf_write_ack: got latency %0d, want 1", lat); else passes++;
    busAccess(1'b1, 1'b0, UARTTX_STATUS, 4'hF, 32'h0, rd, lat, se);
    checks++; if (rd !== 32'h80D) $display("[TB] FAIL ovf_set: got %h, want 0000080d", rd); else passes++;
    busAccess(1'b1, 1'b0, UARTTX_STATUS, 4'hF, 32'h0, rd, lat, se);
    checks++; if (rd !== 32'h805) $display("[TB] FAIL ovf_cleared: got %h, want 00000805", rd); else passes++;
  endtask

  task automatic test_push_while_full();
    logic [31:0] rd; int lat; longint se; longint c1; int f0;
    f0 = frameCount; lastValid = 1'b0; b2bMode = 1'b1; c1 = 0;
    for (int i = 0; i < 9; i++) begin
      busAccess(1'b0, 1'b1, UARTTX_DATA, 4'h1, 32'(8'h11 + i), rd, lat, se);
      expQ.push_back(8'(8'h11 + i));
      if (i == 0) c1 = se;
    end
    busAccess(1'b0, 1'b0, UARTTX_STATUS, 4'hF, 32'h0, rd, lat, se);
    checks++; if (rd !== 32'h805) $display("[TB] FAIL pwf_full: got %h, want 00000805", rd); else passes++;
    // Second pop lands on edge c1+42; aim the write's effect edge there.
    while (cycle < c1 + 40) begin @(posedge clk); #1; end
    busAccess(1'b0, 1'b1, UARTTX_DATA, 4'h1, 32'h0000001A, rd, lat, se);
    expQ.push_back(8'h1A);
    checks++; if (se != c1 + 42) $display("[TB] FAIL pwf_timing: got edge %0d, want %0d", se, c1 + 42); else passes++;
    busAccess(1'b0, 1'b0, UARTTX_STATUS, 4'hF, 32'h0, rd, lat, se);
    checks++; if (rd !== 32'h805) $display("[TB] FAIL pwf_status: got %h, want 00000805", rd); else passes++;
    waitFrames(f0 + 10, 600);
    checks++; if (frameCount != f0 + 10) $display("[TB] FAIL pwf_frames: got %0d, want 10", frameCount - f0); else passes++;
    checks++; if (expQ.size() != 0) $display("[TB] FAIL pwf_queue: got %0d left, want 0", expQ.size()); else passes++;
    b2bMode = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd; int lat; longint se; longint p; int f0; bit anyLow;
    f0 = frameCount;
    busAccess(1'b0, 1'b1, UARTTX_DATA, 4'h1, 32'h000000C3, rd, lat, se);
    p = se + 1;
    expQ.push_back(8'hC3);
    busAccess(1'b0, 1'b1, UARTTX_DATA, 4'h1, 32'h0000003C, rd, lat, se);
    expQ.push_back(8'h3C);
    while (cycle < p + 17) begin @(posedge clk); #1; end
    checks++; if (fTxd !== 1'b0) $display("[TB] FAIL mid_bit3: got %b, want 0", fTxd); else passes++;
    fRst = 1'b1;
    fStb = 1'b1; fWe = 1'b1; fAdr = UARTTX_DATA; fSel = 4'h1; fDin = 32'h00000077;
    @(posedge clk); #1;
    checks++; if (fTxd !== 1'b1) $display("[TB] FAIL mid_reset_txd: got %b, want 1", fTxd); else passes++;
    checks++; if (fAck !== 1'b0) $display("[TB] FAIL mid_reset_ack: got %b, want 0", fAck); else passes++;
    fRst = 1'b0; fStb = 1'b0;
    expQ.delete();
    anyLow = 1'b0;
    repeat (100) begin @(posedge clk); #1; if (fTxd !== 1'b1) anyLow = 1'b1; end
    checks++; if (anyLow || frameCount != f0) $display("[TB] FAIL mid_residual: got low=%b frames=%0d, want low=0 frames=0", anyLow, frameCount - f0); else passes++;
    busAccess(1'b0, 1'b0, UARTTX_STATUS, 4'hF, 32'h0, rd, lat, se);
    checks++; if (rd !== 32'h2) $display("[TB] FAIL mid_status: got %h, want 00000002", rd); else passes++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_frame_latency();
    test_held_strobe();
    test_ignored_writes();
    test_overflow();
    test_push_while_full();
    test_reset_midframe();
    repeat (5) @(posedge clk);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
